// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the EX/MEM-side inputs and the IF / MEM/WB-side outputs of
// the memory stage so that they travel as one bundle.
//   slave  : the memory stage itself (control/data in, branch + MEM/WB out)
//   master : whoever drives the stage (pipeline register or testbench)
// Handshake: there is no valid/ready pair. Every rising clock edge with Stall_in=0
// is a transfer; Stall_in=1 freezes the stage for that edge.
interface mem_stage_if;
    // EX/MEM control bits
    logic        MemWrite_in;
    logic        MemRead_in;
    logic        Branch_in;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    // EX/MEM data
    logic [31:0] ALUAddResult_in;
    logic        Zero_in;
    logic [31:0] ALUResult_in;
    logic [31:0] ReadData2_in;
    logic [4:0]  WriteReg_in;
    logic        Stall_in;
    // Branch decision to IF (combinational)
    logic        PCSrc_out;
    logic [31:0] BranchTarget_out;
    // MEM/WB register outputs
    logic        MemtoReg_out;
    logic        RegWrite_out;
    logic [31:0] ReadData_out;
    logic [31:0] ALUResult_out;
    logic [4:0]  WriteReg_out;
    // Status
    logic        MisalignErr_out;
    logic [15:0] StoreCount_out;

    modport slave (
        input  MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in,
        input  ALUAddResult_in, Zero_in, ALUResult_in, ReadData2_in, WriteReg_in,
        input  Stall_in,
        output PCSrc_out, BranchTarget_out,
        output MemtoReg_out, RegWrite_out, ReadData_out, ALUResult_out, WriteReg_out,
        output MisalignErr_out, StoreCount_out
    );

    modport master (
        output MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in,
        output ALUAddResult_in, Zero_in, ALUResult_in, ReadData2_in, WriteReg_in,
        output Stall_in,
        input  PCSrc_out, BranchTarget_out,
        input  MemtoReg_out, RegWrite_out, ReadData_out, ALUResult_out, WriteReg_out,
        input  MisalignErr_out, StoreCount_out
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage pipeline. Holds DEPTH words of data memory,
// performs word-aligned loads/stores, resolves the branch decision for IF and
// registers the MEM/WB outputs.
// Ports:
//   Clk_in : clock, all state on rising edge
//   Rst    : synchronous active-low reset (registers only, memory untouched)
//   bus    : mem_stage_if.slave, control/data in, branch + MEM/WB + status out
// Parameter DEPTH: number of 32-bit words, power of two in 4..65536.
module mem_stage #(
    parameter int DEPTH = 1024
) (
    input  logic         Clk_in,
    input  logic         Rst,
    mem_stage_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    // Memory starts at all-zero and is never cleared by reset.
    logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

    logic [AW-1:0] idx;
    logic          access;
    logic          misalign;
    logic          store_en;
    logic          capture;
    logic [31:0]   rd_word;

    logic          memtoreg_q, memtoreg_d;
    logic          regwrite_q, regwrite_d;
    logic [31:0]   rdata_q,    rdata_d;
    logic [31:0]   alu_q,      alu_d;
    logic [4:0]    wreg_q,     wreg_d;
    logic          err_q,      err_d;
    logic [15:0]   cnt_q,      cnt_d;

    // Address bits above the word index are deliberately ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ALUResult_in[31:AW+2];

    assign idx      = bus.ALUResult_in[AW+1:2];
    assign access   = bus.MemRead_in | bus.MemWrite_in;
    assign misalign = access & (bus.ALUResult_in[1:0] != 2'b00);
    assign capture  = Rst & ~bus.Stall_in;
    assign store_en = capture & bus.MemWrite_in & ~misalign;
    // Read happens before the write lands, so a same-address read/write returns old data.
    assign rd_word  = mem[idx];

    // Branch resolution: purely combinational.
    assign bus.PCSrc_out        = bus.Branch_in & bus.Zero_in;
    assign bus.BranchTarget_out = bus.ALUAddResult_in;

    always_comb begin
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        rdata_d    = rdata_q;
        alu_d      = alu_q;
        wreg_d     = wreg_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (!bus.Stall_in) begin
            memtoreg_d = bus.MemtoReg_in;
            regwrite_d = bus.RegWrite_in & ~misalign;
            rdata_d    = (bus.MemRead_in && !misalign) ? rd_word : 32'h0;
            alu_d      = bus.ALUResult_in;
            wreg_d     = bus.WriteReg_in;
            if (misalign) begin
                err_d = 1'b1;
            end
            if (bus.MemWrite_in && !misalign && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk_in) begin
        if (!Rst) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            rdata_q    <= 32'h0;
            alu_q      <= 32'h0;
            wreg_q     <= 5'h0;
            err_q      <= 1'b0;
            cnt_q      <= 16'h0;
        end else begin
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            wreg_q     <= wreg_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Reset and stall both gate store_en, so neither ever writes memory.
    always_ff @(posedge Clk_in) begin
        if (store_en) begin
            mem[idx] <= bus.ReadData2_in;
        end
    end

    assign bus.MemtoReg_out    = memtoreg_q;
    assign bus.RegWrite_out    = regwrite_q;
    assign bus.ReadData_out    = rdata_q;
    assign bus.ALUResult_out   = alu_q;
    assign bus.WriteReg_out    = wreg_q;
    assign bus.MisalignErr_out = err_q;
    assign bus.StoreCount_out  = cnt_q;
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    mem_stage_if bus ();

    mem_stage #(.DEPTH(DEPTH)) dut (
        .Clk_in (clk),
        .Rst    (rst),
        .bus    (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory as a plain word array; index = (addr / 4) mod DEPTH.
    logic [31:0] ref_mem [DEPTH];
    logic        m_memtoreg, m_regwrite, m_err;
    logic [31:0] m_rdata, m_alu;
    logic [4:0]  m_wreg;
    int          m_cnt;

    task automatic model_edge();
        int unsigned a;
        int unsigned wi;
        bit mis;
        logic [31:0] old;
        a   = bus.ALUResult_in;
        wi  = (a / 4) % DEPTH;
        mis = (bus.MemRead_in || bus.MemWrite_in) && (a % 4 != 0);
        if (!rst) begin
            m_memtoreg = 0; m_regwrite = 0; m_rdata = 0; m_alu = 0;
            m_wreg = 0; m_err = 0; m_cnt = 0;
        end else if (!bus.Stall_in) begin
            old        = ref_mem[wi];
            m_rdata    = (bus.MemRead_in && !mis) ? old : 32'h0;
            m_memtoreg = bus.MemtoReg_in;
            m_regwrite = mis ? 1'b0 : bus.RegWrite_in;
            m_alu      = bus.ALUResult_in;
            m_wreg     = bus.WriteReg_in;
            if (mis) m_err = 1'b1;
            if (bus.MemWrite_in && !mis) begin
                ref_mem[wi] = bus.ReadData2_in;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".memtoreg"}, {31'h0, bus.MemtoReg_out},    {31'h0, m_memtoreg});
        check({tag, ".regwrite"}, {31'h0, bus.RegWrite_out},    {31'h0, m_regwrite});
        check({tag, ".rdata"},    bus.ReadData_out,             m_rdata);
        check({tag, ".alu"},      bus.ALUResult_out,            m_alu);
        check({tag, ".wreg"},     {27'h0, bus.WriteReg_out},    {27'h0, m_wreg});
        check({tag, ".err"},      {31'h0, bus.MisalignErr_out}, {31'h0, m_err});
        check({tag, ".cnt"},      {16'h0, bus.StoreCount_out},  m_cnt[31:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.MemWrite_in = 0; bus.MemRead_in = 0; bus.Branch_in = 0;
        bus.MemtoReg_in = 0; bus.RegWrite_in = 0; bus.ALUAddResult_in = 0;
        bus.Zero_in = 0; bus.ALUResult_in = 0; bus.ReadData2_in = 0;
        bus.WriteReg_in = 0; bus.Stall_in = 0;
    endtask

    // One clock: model consumes the current inputs, DUT sees the edge, compare 1ns later.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        idle_inputs();
        bus.MemWrite_in = 1; bus.ALUResult_in = addr; bus.ReadData2_in = data;
        step("store");
    endtask

    task automatic do_load(input logic [31:0] addr);
        idle_inputs();
        bus.MemRead_in = 1; bus.MemtoReg_in = 1; bus.RegWrite_in = 1;
        bus.ALUResult_in = addr; bus.WriteReg_in = 5'd7;
        step("load");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [31:0] held_rdata;
        logic [15:0] held_cnt;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        m_memtoreg = 0; m_regwrite = 0; m_rdata = 0; m_alu = 0;
        m_wreg = 0; m_err = 0; m_cnt = 0;

        // Reset with busy-looking inputs.
        idle_inputs();
        rst = 0;
        bus.RegWrite_in = 1; bus.ALUResult_in = 32'h44; bus.WriteReg_in = 5'd3;
        step("reset");
        step("reset");
        check("reset.rdata_zero", bus.ReadData_out, 32'h0);
        rst = 1;

        // Store then load.
        do_store(32'h10, 32'hDEADBEEF);
        do_load(32'h10);
        check("st_ld.rdata", bus.ReadData_out, 32'hDEADBEEF);
        check("st_ld.cnt", {16'h0, bus.StoreCount_out}, 32'd1);

        // Address wrap modulo 4*DEPTH.
        do_store(32'h1004, 32'h5A5A5A5A);
        do_load(32'h0004);
        check("wrap.rdata", bus.ReadData_out, 32'h5A5A5A5A);

        // Unwritten word reads back the power-up zero.
        do_load(32'h300);
        check("init.zero", bus.ReadData_out, 32'h0);

        // Same-address read+write returns old word and commits the new one.
        idle_inputs();
        bus.MemRead_in = 1; bus.MemWrite_in = 1; bus.ALUResult_in = 32'h10;
        bus.ReadData2_in = 32'h12345678;
        step("rmw");
        check("rmw.old", bus.ReadData_out, 32'hDEADBEEF);
        do_load(32'h10);
        check("rmw.new", bus.ReadData_out, 32'h12345678);

        // Branch decision is combinational.
        idle_inputs();
        bus.Branch_in = 1; bus.Zero_in = 1; bus.ALUAddResult_in = 32'h400;
        #1;
        check("br.pcsrc1", {31'h0, bus.PCSrc_out}, 32'd1);
        check("br.target", bus.BranchTarget_out, 32'h400);
        bus.Zero_in = 0;
        #1;
        check("br.pcsrc0", {31'h0, bus.PCSrc_out}, 32'd0);
        step("br");

        // Misaligned load: flagged, data and regwrite suppressed, flag sticky.
        idle_inputs();
        bus.MemRead_in = 1; bus.RegWrite_in = 1; bus.ALUResult_in = 32'h13;
        step("mis");
        check("mis.rdata", bus.ReadData_out, 32'h0);
        check("mis.regwrite", {31'h0, bus.RegWrite_out}, 32'd0);
        check("mis.err", {31'h0, bus.MisalignErr_out}, 32'd1);
        // Misaligned store must not write or count.
        idle_inputs();
        bus.MemWrite_in = 1; bus.ALUResult_in = 32'h12; bus.ReadData2_in = 32'hBAD0BAD0;
        step("mis_st");
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            step("clean");
        end
        check("mis.sticky", {31'h0, bus.MisalignErr_out}, 32'd1);
        do_load(32'h10);
        check("mis_st.nowrite", bus.ReadData_out, 32'h12345678);

        // Stall: three held edges with a pending store to word 8.
        held_rdata = bus.ReadData_out;
        held_cnt   = bus.StoreCount_out;
        idle_inputs();
        bus.Stall_in = 1; bus.MemWrite_in = 1; bus.ALUResult_in = 32'h20;
        bus.ReadData2_in = 32'h1; bus.MemRead_in = 0;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.rdata", bus.ReadData_out, held_rdata);
        check("stall.cnt", {16'h0, bus.StoreCount_out}, {16'h0, held_cnt});
        // Misalign during stall is not flagged (flag is already 1, so reset first below).
        do_load(32'h20);
        check("stall.mem8", bus.ReadData_out, 32'h0);

        // Reset priority over stall and pending store; memory survives reset.
        idle_inputs();
        rst = 0;
        bus.Stall_in = 1; bus.MemWrite_in = 1; bus.ALUResult_in = 32'h10;
        bus.ReadData2_in = 32'hFFFFFFFF;
        step("rst_pri");
        check("rst_pri.err", {31'h0, bus.MisalignErr_out}, 32'd0);
        rst = 1;
        do_load(32'h10);
        check("rst_pri.keep", bus.ReadData_out, 32'h12345678);

        // Stalled misaligned access must not raise the flag.
        idle_inputs();
        bus.Stall_in = 1; bus.MemRead_in = 1; bus.ALUResult_in = 32'h7;
        step("stall_mis");
        check("stall_mis.err", {31'h0, bus.MisalignErr_out}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            idle_inputs();
            r = $urandom;
            bus.MemWrite_in     = ($urandom_range(0, 99) < 40);
            bus.MemRead_in      = ($urandom_range(0, 99) < 50);
            bus.Branch_in       = r[0];
            bus.Zero_in         = r[1];
            bus.MemtoReg_in     = r[2];
            bus.RegWrite_in     = r[3];
            bus.ALUAddResult_in = $urandom;
            bus.ReadData2_in    = $urandom;
            bus.WriteReg_in     = 5'($urandom_range(0, 31));
            // Small word range so loads hit earlier stores; high bits exercise wrap.
            bus.ALUResult_in    = 32'($urandom_range(0, 31)) << 2;
            if (r[4]) bus.ALUResult_in[15:12] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 8) bus.ALUResult_in[1:0] = 2'($urandom_range(1, 3));
            bus.Stall_in        = ($urandom_range(0, 99) < 15);
            rst                 = !($urandom_range(0, 99) < 3);
            #1;
            check("rand.pcsrc", {31'h0, bus.PCSrc_out}, {31'h0, bus.Branch_in & bus.Zero_in});
            check("rand.target", bus.BranchTarget_out, bus.ALUAddResult_in);
            step("rand");
        end
        rst = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 1024, means the number of 32-bit data-memory words; it SHALL be a power of two, 4..65536.
REQ-002 Clk_in  in  1  is the single clock; all state SHALL update on its rising edge only.
REQ-003 Rst  in  1  is the reset: synchronous, active-low; Rst=0 at a rising edge of Clk_in resets the block.
REQ-004 MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in  in  1 each  are control bits from the EX/MEM register.
REQ-005 ALUAddResult_in  in  32  is the branch target; Zero_in  in  1  is the ALU zero flag.
REQ-006 ALUResult_in  in  32  is the byte address or ALU result; ReadData2_in  in  32  is the store data.
REQ-007 WriteReg_in  in  5  is the destination register number.
REQ-008 Stall_in  in  1  holds the MEM/WB outputs and blocks memory writes while high.
REQ-009 PCSrc_out  out  1  and BranchTarget_out  out  32  are the combinational branch decision and branch target to IF.
REQ-010 MemtoReg_out, RegWrite_out  out  1 each; ReadData_out, ALUResult_out  out  32 each; WriteReg_out  out  5  are the registered MEM/WB outputs.
REQ-011 MisalignErr_out  out  1  is a sticky misaligned-access flag; StoreCount_out  out  16  is the committed-store count.

Function
REQ-012 PCSrc_out SHALL equal Branch_in AND Zero_in; BranchTarget_out SHALL equal ALUAddResult_in; both are combinational, with no clock or reset dependency.
REQ-013 Word index SHALL be ALUResult_in[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-014 An access is misaligned when (MemRead_in OR MemWrite_in)=1 and ALUResult_in[1:0] != 0.
REQ-015 A store SHALL commit at the edge when Rst=1, Stall_in=0, MemWrite_in=1 and the access is aligned: mem[index] <= ReadData2_in.
REQ-016 When Rst=1 and Stall_in=0, each edge SHALL load the MEM/WB outputs: MemtoReg_out, RegWrite_out, ALUResult_out and WriteReg_out take their inputs, giving 1-cycle latency.
REQ-017 ReadData_out SHALL load mem[index] as it was before that edge (read-old-data) when MemRead_in=1 and the access is aligned; otherwise it SHALL load 0.
REQ-018 MemRead_in=MemWrite_in=1 at the same address SHALL commit the write and return the old word.
REQ-019 On a misaligned access: no write; ReadData_out <= 0; RegWrite_out <= 0; MisalignErr_out <= 1.
REQ-020 MisalignErr_out SHALL remain 1 until reset.
REQ-021 StoreCount_out SHALL increment by 1 per committed store and saturate at 0xFFFF.
REQ-022 While Stall_in=1 and Rst=1: all registered outputs, MisalignErr_out and StoreCount_out hold; memory is unchanged; misalignment is not flagged.

Reset
REQ-023 Rst=0 at an edge SHALL set MemtoReg_out, RegWrite_out, ReadData_out, ALUResult_out, WriteReg_out, MisalignErr_out and StoreCount_out to 0.
REQ-024 Reset SHALL take priority over Stall_in and over any pending store; no memory write occurs in a reset cycle.
REQ-025 Memory contents SHALL be unaffected by Rst and SHALL initialise to all-zero at time zero.
REQ-026 A reset arriving mid-stall SHALL release the hold; normal capture resumes at the first edge with Rst=1 and Stall_in=0.

Verification
REQ-027 Store-load, at the default DEPTH=1024 (all wrap addresses below assume it):
- cycle n: MemWrite=1, ALUResult=0x10, ReadData2=0xDEADBEEF;
- cycle n+1: MemRead=1, MemtoReg=1, ALUResult=0x10;
- required: ReadData_out=0xDEADBEEF after edge n+2; StoreCount_out=1.
REQ-028 Wrap: store 0x5A5A5A5A to ALUResult=0x1004, then load 0x0004 -> ReadData_out=0x5A5A5A5A.
REQ-029 Misalign: MemRead=1, RegWrite=1, ALUResult=0x13 -> ReadData_out=0, RegWrite_out=0, MisalignErr_out=1; the flag persists through 10 clean cycles and clears only on Rst=0.
REQ-030 Stall: Stall_in=1 for 3 cycles with MemWrite=1, ALUResult=0x20, ReadData2=0x1 -> outputs frozen at prior values, mem[8] unchanged, StoreCount_out unchanged.
REQ-031 Branch: Branch=1, Zero=1, ALUAddResult=0x400 -> PCSrc_out=1 and BranchTarget_out=0x400 in the same cycle; with Zero=0 -> PCSrc_out=0.
REQ-032 Reset priority: Rst=0 together with Stall_in=1 and MemWrite=1 -> all registered outputs 0 at that edge and memory not written; previously stored words still read back after reset.
